// File: rtl/mem_bus_arbiter.sv
// Three-requester memory bus arbiter: round-robin grant with burst limit,
// read-ack routing back to the owner, and throttling on outstanding reads.
module mem_bus_arbiter #(
  parameter int BURST_MAX   = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_request,
  input  logic [2:0]  i_write,
  input  logic [11:0] i_bank,
  input  logic [71:0] i_address,
  input  logic [95:0] i_wdata,
  output logic [2:0]  o_busy,
  output logic [2:0]  o_ack,
  output logic [31:0] o_rdata,
  output logic        o_request,
  output logic        o_write,
  output logic [3:0]  o_bank,
  output logic [23:0] o_address,
  output logic [31:0] o_data,
  input  logic        i_busy,
  input  logic        i_ack,
  input  logic [31:0] i_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
  localparam logic [2:0] PEND_MAX   = 3'(MAX_PENDING);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] burst_q, burst_d;
  logic [2:0] pending_q, pending_d;

  logic       own_req, accept, rd_acc, ack_dec, ack_fwd;
  logic [1:0] c1, c2, pick;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      2'd2:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  // Pointer index has highest priority, then walks upward modulo 3.
  assign c1 = inc3(ptr_q);
  assign c2 = inc3(c1);
  always_comb begin
    pick = c2;
    if (req_at(i_request, c1))    pick = c1;
    if (req_at(i_request, ptr_q)) pick = ptr_q;
  end

  always_comb begin
    own_req   = 1'b0;
    o_write   = 1'b0;
    o_bank    = '0;
    o_address = '0;
    o_data    = '0;
    case (owner_q)
      2'd0: begin
        own_req = i_request[0]; o_write = i_write[0]; o_bank = i_bank[3:0];
        o_address = i_address[23:0]; o_data = i_wdata[31:0];
      end
      2'd1: begin
        own_req = i_request[1]; o_write = i_write[1]; o_bank = i_bank[7:4];
        o_address = i_address[47:24]; o_data = i_wdata[63:32];
      end
      2'd2: begin
        own_req = i_request[2]; o_write = i_write[2]; o_bank = i_bank[11:8];
        o_address = i_address[71:48]; o_data = i_wdata[95:64];
      end
      default: ;
    endcase
  end

  assign o_request = !i_reset && (state_q == GRANT) && own_req && (pending_q < PEND_MAX);
  assign accept    = o_request && !i_busy;
  assign rd_acc    = accept && !o_write;
  assign ack_dec   = i_ack && (pending_q != 3'd0);
  assign ack_fwd   = ack_dec && !i_reset && ((state_q == GRANT) || (state_q == DRAIN));
  assign o_rdata   = i_data;

  always_comb begin
    o_busy = 3'b111;
    o_ack  = 3'b000;
    for (int n = 0; n < 3; n++) begin
      if (!i_reset && owner_q == 2'(n)) begin
        if (state_q == GRANT) o_busy[n] = i_busy || (pending_q == PEND_MAX);
        if (ack_fwd)          o_ack[n]  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    pending_d = pending_q;
    if (accept) burst_d = burst_q + 8'd1;
    // A read accept and an ack in the same cycle cancel out.
    if (rd_acc && !ack_dec)      pending_d = pending_q + 3'd1;
    else if (!rd_acc && ack_dec) pending_d = pending_q - 3'd1;
    case (state_q)
      IDLE: if (|i_request) begin
        owner_d = pick;
        burst_d = 8'd0;
        state_d = GRANT;
      end
      GRANT: if ((accept && burst_q == BURST_LAST) || !own_req) begin
        ptr_d   = inc3(owner_q);
        state_d = (pending_d != 3'd0) ? DRAIN : IDLE;
      end
      DRAIN: if (pending_d == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      burst_q   <= 8'd0;
      pending_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      pending_q <= pending_d;
    end
  end
endmodule
